sparc_exu_alu_zcc: RTL and testbench

- Condition-code stage directly downstream of the ALU sum-predict logic.
- Consumes the 64-bit sum-predict vector, which is all-zero iff the sum is zero, plus the adder's sign, carry and overflow bits.
- Pipelines the zero-detect over two cycles and assembles icc/xcc (N,Z,V,C).
- Maintains a per-thread CCR file with stall, kill and a same-thread forwarding path.

---
 rtl/sparc_exu_alu_zcc_pkg.sv | 30 +++
 rtl/sparc_exu_zcc_chunkz.sv | 27 ++
 rtl/sparc_exu_alu_zcc.sv | 151 +++++++++++++++
 tb/tb_sparc_exu_alu_zcc.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_exu_alu_zcc_pkg.sv
// ============================================================================
// Module   : sparc_exu_alu_zcc_pkg
// Brief    : Shared CCR bit positions, CCR type and reset value for the ZCC stage
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sparc_exu_alu_zcc_pkg;

    localparam int ZCC_XN = 7;
    localparam int ZCC_XZ = 6;
    localparam int ZCC_XV = 5;
    localparam int ZCC_XC = 4;
    localparam int ZCC_IN = 3;
    localparam int ZCC_IZ = 2;
    localparam int ZCC_IV = 1;
    localparam int ZCC_IC = 0;

    typedef logic [7:0] ccr_t;

    localparam ccr_t CCR_RST = 8'h00;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic ccr_par(input ccr_t v);
        return ^v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sparc_exu_zcc_chunkz.sv
// ============================================================================
// Module   : sparc_exu_zcc_chunkz
// Brief    : Per-chunk NOR reduction; chunk_z[i] is set when chunk i is all zero
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sparc_exu_zcc_chunkz
    import sparc_exu_alu_zcc_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int CHUNK_W = 8
) (
    input  logic [DATA_W-1:0]         data_in,
    output logic [DATA_W/CHUNK_W-1:0] chunk_z
);

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W / CHUNK_W; gi++) begin : g_chunk
            assign chunk_z[gi] = ~|data_in[gi*CHUNK_W +: CHUNK_W];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/sparc_exu_alu_zcc.sv
// ============================================================================
// Module   : sparc_exu_alu_zcc
// Brief    : Two-stage zero detect, icc/xcc assembly and per-thread CCR file
//            with forwarding. Macro SPARC_EXU_ZCC_PARITY_EN adds CCR parity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sparc_exu_alu_zcc
    import sparc_exu_alu_zcc_pkg::*;
#(
    parameter int NUM_THR = 4,
    parameter int DATA_W  = 64,
    parameter int CHUNK_W = 8,
    parameter int TID_W   = (NUM_THR > 1) ? $clog2(NUM_THR) : 1
) (
    input  logic              rclk,
    input  logic              arst_l,
    input  logic [DATA_W-1:0] spr_in,
    input  logic              sum63_e,
    input  logic              sum31_e,
    input  logic              cout64_e,
    input  logic              cout32_e,
    input  logic              ov64_e,
    input  logic              ov32_e,
    input  logic              vld_e,
    input  logic              ccwe_e,
    input  logic [TID_W-1:0]  tid_e,
    input  logic              stall,
    input  logic              kill_m,
    input  logic [TID_W-1:0]  rd_tid,
    output logic [7:0]        ccr_rd,
    output logic              zero64_m,
    output logic              zero32_m,
    output logic              vld_m
`ifdef SPARC_EXU_ZCC_PARITY_EN
    ,
    output logic              ccr_perr
`endif
);

    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int NLO    = NCHUNK / 2;

    logic [NCHUNK-1:0] w_chunk_z;
    logic [NCHUNK-1:0] r_chunk_z;
    logic              r_sum63_m;
    logic              r_sum31_m;
    logic              r_cout64_m;
    logic              r_cout32_m;
    logic              r_ov64_m;
    logic              r_ov32_m;
    logic [TID_W-1:0]  r_tid_m;
    logic              r_ccwe_m;
    logic              r_vld_m;

    ccr_t              w_ccr_next;
    logic              w_we;
    ccr_t              r_ccr [NUM_THR];

    sparc_exu_zcc_chunkz #(
        .DATA_W  (DATA_W),
        .CHUNK_W (CHUNK_W)
    ) u_chunkz (
        .data_in (spr_in),
        .chunk_z (w_chunk_z)
    );

    // Chunk flags are captured even for bubbles; consumers qualify with vld_m.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_chunk_z  <= '0;
            r_sum63_m  <= 1'b0;
            r_sum31_m  <= 1'b0;
            r_cout64_m <= 1'b0;
            r_cout32_m <= 1'b0;
            r_ov64_m   <= 1'b0;
            r_ov32_m   <= 1'b0;
            r_tid_m    <= '0;
            r_ccwe_m   <= 1'b0;
            r_vld_m    <= 1'b0;
        end else if (!stall) begin
            r_chunk_z  <= w_chunk_z;
            r_sum63_m  <= sum63_e;
            r_sum31_m  <= sum31_e;
            r_cout64_m <= cout64_e;
            r_cout32_m <= cout32_e;
            r_ov64_m   <= ov64_e;
            r_ov32_m   <= ov32_e;
            r_tid_m    <= tid_e;
            r_ccwe_m   <= ccwe_e;
            r_vld_m    <= vld_e;
        end
    end

    assign zero64_m = &r_chunk_z;
    assign zero32_m = &r_chunk_z[NLO-1:0];
    assign vld_m    = r_vld_m;

    always_comb begin
        w_ccr_next         = CCR_RST;
        w_ccr_next[ZCC_XN] = r_sum63_m;
        w_ccr_next[ZCC_XZ] = zero64_m;
        w_ccr_next[ZCC_XV] = r_ov64_m;
        w_ccr_next[ZCC_XC] = r_cout64_m;
        w_ccr_next[ZCC_IN] = r_sum31_m;
        w_ccr_next[ZCC_IZ] = zero32_m;
        w_ccr_next[ZCC_IV] = r_ov32_m;
        w_ccr_next[ZCC_IC] = r_cout32_m;
    end

    // A killed M op is squashed simply by not writing; the next load replaces it.
    assign w_we = r_vld_m & r_ccwe_m & ~kill_m & ~stall;

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            for (int i = 0; i < NUM_THR; i++) begin
                r_ccr[i] <= CCR_RST;
            end
        end else if (w_we) begin
            r_ccr[r_tid_m] <= w_ccr_next;
        end
    end

    always_comb begin
        ccr_rd = r_ccr[rd_tid];
        if (w_we && (r_tid_m == rd_tid)) begin
            ccr_rd = w_ccr_next;
        end
    end

`ifdef SPARC_EXU_ZCC_PARITY_EN
    logic r_par [NUM_THR];

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            for (int i = 0; i < NUM_THR; i++) begin
                r_par[i] <= ccr_par(CCR_RST);
            end
        end else if (w_we) begin
            r_par[r_tid_m] <= ccr_par(w_ccr_next);
        end
    end

    // Only the stored entry is checked; forwarded data never raises an error.
    assign ccr_perr = ccr_par(r_ccr[rd_tid]) ^ r_par[rd_tid];
`endif

endmodule

`default_nettype wire

// File: tb/tb_sparc_exu_alu_zcc.sv
// ============================================================================
// Module   : tb_sparc_exu_alu_zcc
// Brief    : Self-checking bench for sparc_exu_alu_zcc (directed + random)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sparc_exu_alu_zcc;

    logic        rclk;
    logic        arst_l;
    logic [63:0] spr_in;
    logic        sum63_e, sum31_e, cout64_e, cout32_e, ov64_e, ov32_e;
    logic        vld_e, ccwe_e;
    logic [1:0]  tid_e;
    logic        stall, kill_m;
    logic [1:0]  rd_tid;
    logic [7:0]  ccr_rd;
    logic        zero64_m, zero32_m, vld_m;
`ifdef SPARC_EXU_ZCC_PARITY_EN
    logic        ccr_perr;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: one pending op in M plus the architectural CCR per thread.
    logic [7:0] exp_ccr [4];
    logic       m_vld, m_ccwe, m_z64, m_z32;
    logic [1:0] m_tid;
    logic [7:0] m_ccr;

    sparc_exu_alu_zcc dut (
        .rclk     (rclk),
        .arst_l   (arst_l),
        .spr_in   (spr_in),
        .sum63_e  (sum63_e),
        .sum31_e  (sum31_e),
        .cout64_e (cout64_e),
        .cout32_e (cout32_e),
        .ov64_e   (ov64_e),
        .ov32_e   (ov32_e),
        .vld_e    (vld_e),
        .ccwe_e   (ccwe_e),
        .tid_e    (tid_e),
        .stall    (stall),
        .kill_m   (kill_m),
        .rd_tid   (rd_tid),
        .ccr_rd   (ccr_rd),
        .zero64_m (zero64_m),
        .zero32_m (zero32_m),
        .vld_m    (vld_m)
`ifdef SPARC_EXU_ZCC_PARITY_EN
        ,
        .ccr_perr (ccr_perr)
`endif
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [7:0] ccr_from_inputs();
        return {sum63_e, (spr_in == 64'd0), ov64_e, cout64_e,
                sum31_e, (spr_in[31:0] == 32'd0), ov32_e, cout32_e};
    endfunction

    function automatic logic [7:0] exp_rd(input logic [1:0] t);
        if (m_vld && m_ccwe && !kill_m && !stall && (m_tid == t))
            return m_ccr;
        return exp_ccr[t];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) exp_ccr[i] = 8'h00;
        m_vld = 0; m_ccwe = 0; m_tid = 0; m_ccr = 8'h00; m_z64 = 0; m_z32 = 0;
    endtask

    // Advance one edge, updating the model with what the edge should do.
    task automatic tick();
        if (arst_l && !stall) begin
            if (m_vld && m_ccwe && !kill_m) exp_ccr[m_tid] = m_ccr;
            m_vld  = vld_e;
            m_ccwe = ccwe_e;
            m_tid  = tid_e;
            m_ccr  = ccr_from_inputs();
            m_z64  = (spr_in == 64'd0);
            m_z32  = (spr_in[31:0] == 32'd0);
        end
        @(posedge rclk);
        #1;
    endtask

    task automatic drive_op(input logic [63:0] spr, input logic s63, input logic s31,
                            input logic c64, input logic c32, input logic v64,
                            input logic v32, input logic [1:0] tid, input logic we);
        spr_in = spr; sum63_e = s63; sum31_e = s31; cout64_e = c64; cout32_e = c32;
        ov64_e = v64; ov32_e = v32; tid_e = tid; ccwe_e = we; vld_e = 1'b1;
    endtask

    task automatic bubble();
        vld_e = 1'b0; ccwe_e = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (vld_m !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", vld_m); end
        checks++; if (zero64_m !== 1'b0 || zero32_m !== 1'b0) begin
            errors++; $display("FAIL reset_zero: got %b%b want 00", zero64_m, zero32_m);
        end
        @(posedge rclk); #1;
        arst_l = 1'b1;
        model_reset();
        for (int t = 0; t < 4; t++) begin
            rd_tid = t[1:0]; #1;
            checks++; if (ccr_rd !== 8'h00) begin
                errors++; $display("FAIL reset_ccr tid%0d: got %h want 00", t, ccr_rd);
            end
        end
        checks++; if (vld_m !== 1'b0) begin errors++; $display("FAIL reset_vld_rel: got %b want 0", vld_m); end
    endtask

    task automatic test_zero_result();
        drive_op(64'd0, 0, 0, 0, 0, 0, 0, 2'd2, 1'b1);
        tick();
        bubble(); rd_tid = 2'd2; #1;
        checks++; if (zero64_m !== 1'b1 || zero32_m !== 1'b1 || vld_m !== 1'b1) begin
            errors++; $display("FAIL zero_m_flags: got z64=%b z32=%b vld=%b want 1 1 1", zero64_m, zero32_m, vld_m);
        end
        checks++; if (ccr_rd !== 8'h44) begin errors++; $display("FAIL zero_fwd: got %h want 44", ccr_rd); end
        tick();
        checks++; if (ccr_rd !== 8'h44) begin errors++; $display("FAIL zero_ccr2: got %h want 44", ccr_rd); end
    endtask

    task automatic test_kill();
        drive_op(64'hFFFF_0000_0000_0000, 1, 0, 1, 0, 0, 0, 2'd1, 1'b1);
        tick();
        bubble(); kill_m = 1'b1; rd_tid = 2'd1; #1;
        checks++; if (ccr_rd !== 8'h00) begin errors++; $display("FAIL kill_nofwd: got %h want 00", ccr_rd); end
        tick();
        kill_m = 1'b0; #1;
        checks++; if (ccr_rd !== 8'h00 || vld_m !== 1'b0) begin
            errors++; $display("FAIL kill_ccr1: got %h vld=%b want 00 vld=0", ccr_rd, vld_m);
        end
    endtask

    task automatic test_low_half();
        drive_op(64'hFFFF_0000_0000_0000, 1, 0, 1, 0, 0, 0, 2'd1, 1'b1);
        tick();
        bubble(); rd_tid = 2'd1; #1;
        checks++; if (zero64_m !== 1'b0 || zero32_m !== 1'b1) begin
            errors++; $display("FAIL low_flags: got z64=%b z32=%b want 0 1", zero64_m, zero32_m);
        end
        checks++; if (ccr_rd !== 8'h94) begin errors++; $display("FAIL low_fwd: got %h want 94", ccr_rd); end
        tick();
        checks++; if (ccr_rd !== 8'h94) begin errors++; $display("FAIL low_ccr1: got %h want 94", ccr_rd); end
    endtask

    task automatic test_stall();
        drive_op(64'd0, 0, 1, 0, 0, 0, 1, 2'd3, 1'b1);
        tick();
        stall = 1'b1; rd_tid = 2'd3;
        drive_op(64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 1, 1, 1, 1, 2'd3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (ccr_rd !== 8'h00 || zero64_m !== 1'b1 || vld_m !== 1'b1) begin
                errors++; $display("FAIL stall_hold%0d: got ccr=%h z64=%b vld=%b want 00 1 1", k, ccr_rd, zero64_m, vld_m);
            end
            tick();
        end
        bubble(); stall = 1'b0; #1;
        checks++; if (ccr_rd !== 8'h4E) begin errors++; $display("FAIL stall_fwd: got %h want 4e", ccr_rd); end
        tick();
        checks++; if (ccr_rd !== 8'h4E || vld_m !== 1'b0) begin
            errors++; $display("FAIL stall_write: got %h vld=%b want 4e vld=0", ccr_rd, vld_m);
        end
        tick();
        checks++; if (ccr_rd !== 8'h4E) begin errors++; $display("FAIL stall_after: got %h want 4e", ccr_rd); end
    endtask

    task automatic test_back_to_back();
        rd_tid = 2'd0;
        drive_op(64'd0, 0, 0, 0, 0, 0, 0, 2'd0, 1'b1);
        tick();
        drive_op(64'd1, 0, 0, 1, 1, 0, 0, 2'd0, 1'b1); #1;
        checks++; if (ccr_rd !== 8'h44) begin errors++; $display("FAIL b2b_first: got %h want 44", ccr_rd); end
        tick();
        bubble(); #1;
        checks++; if (ccr_rd !== 8'h11) begin errors++; $display("FAIL b2b_second: got %h want 11", ccr_rd); end
        tick();
        checks++; if (ccr_rd !== 8'h11) begin errors++; $display("FAIL b2b_final: got %h want 11", ccr_rd); end
    endtask

`ifdef SPARC_EXU_ZCC_PARITY_EN
    task automatic test_parity();
        rd_tid = 2'd0; #1;
        checks++; if (ccr_perr !== 1'b0) begin errors++; $display("FAIL perr_clean: got %b want 0", ccr_perr); end
        force dut.r_ccr[0] = 8'h10;
        #1;
        checks++; if (ccr_perr !== 1'b1) begin errors++; $display("FAIL perr_flip: got %b want 1", ccr_perr); end
        release dut.r_ccr[0];
    endtask
`endif

    task automatic test_reset_mid();
        drive_op(64'd0, 1, 1, 1, 1, 1, 1, 2'd2, 1'b1);
        tick();
        rd_tid = 2'd2;
        #2 arst_l = 1'b0;
        #1;
        model_reset();
        checks++; if (vld_m !== 1'b0 || ccr_rd !== 8'h00 || zero64_m !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got vld=%b ccr=%h z64=%b want 0 00 0", vld_m, ccr_rd, zero64_m);
        end
        bubble();
        @(posedge rclk); #1;
        arst_l = 1'b1; #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: spr_in = 64'd0;
                1: spr_in = {$urandom(), 32'd0};
                2: spr_in = {$urandom(), $urandom()};
                default: spr_in = {56'd0, 8'($urandom())};
            endcase
            {sum63_e, sum31_e, cout64_e, cout32_e, ov64_e, ov32_e} = 6'($urandom());
            vld_e  = ($urandom_range(0, 9) < 8);
            ccwe_e = ($urandom_range(0, 9) < 7);
            tid_e  = 2'($urandom());
            stall  = ($urandom_range(0, 3) == 0);
            kill_m = ($urandom_range(0, 4) == 0);
            rd_tid = 2'($urandom());
            #1;
            checks++; if (vld_m !== m_vld) begin
                errors++; $display("FAIL rnd_vld @%0d: got %b want %b", n, vld_m, m_vld);
            end
            checks++; if (ccr_rd !== exp_rd(rd_tid)) begin
                errors++; $display("FAIL rnd_ccr @%0d tid%0d: got %h want %h", n, rd_tid, ccr_rd, exp_rd(rd_tid));
            end
            if (m_vld) begin
                checks++; if (zero64_m !== m_z64 || zero32_m !== m_z32) begin
                    errors++; $display("FAIL rnd_zero @%0d: got %b%b want %b%b", n, zero64_m, zero32_m, m_z64, m_z32);
                end
            end
            tick();
        end
        stall = 1'b0; kill_m = 1'b0; bubble();
        tick(); tick();
        for (int t = 0; t < 4; t++) begin
            rd_tid = t[1:0]; #1;
            checks++; if (ccr_rd !== exp_ccr[t]) begin
                errors++; $display("FAIL rnd_final tid%0d: got %h want %h", t, ccr_rd, exp_ccr[t]);
            end
        end
    endtask

    initial begin
        arst_l = 1'b0; spr_in = '0;
        sum63_e = 0; sum31_e = 0; cout64_e = 0; cout32_e = 0; ov64_e = 0; ov32_e = 0;
        vld_e = 0; ccwe_e = 0; tid_e = 0; stall = 0; kill_m = 0; rd_tid = 0;
        model_reset();
        test_reset();
        test_zero_result();
        test_kill();
        test_low_half();
        test_stall();
        test_back_to_back();
`ifdef SPARC_EXU_ZCC_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
